// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: PC + imem req/ack/rvalid fetch FSM, instruction register with decode fields, redirect/drop handling.
// Define FETCH_PERF_CNT_EN to add the fetch_count/stall_count performance counters.
module instr_fetch_unit #(
    parameter int ADDR_W = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int PC_STEP = 4
) (
    input  logic              clk,
    input  logic              reset,
    output logic [ADDR_W-1:0] imem_addr,
    output logic              imem_req,
    input  logic              imem_ack,
    input  logic              imem_rvalid,
    input  logic [31:0]       imem_rdata,
    input  logic              redirect_en,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              dec_ready,
    output logic              instr_valid,
    output logic [ADDR_W-1:0] pc_out,
    output logic [5:0]        opcode,
    output logic [4:0]        rs,
    output logic [4:0]        rt,
    output logic [4:0]        rd,
    output logic [3:0]        funct,
    output logic [15:0]       imm16
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]       fetch_count,
    output logic [31:0]       stall_count
`endif
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d, pc_out_q, pc_out_d;
    logic [31:0]       ir_q, ir_d;
    logic              valid_q, valid_d, drop_q, drop_d;

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        pc_out_d = pc_out_q;
        valid_d  = valid_q;
        drop_d   = drop_q;
        case (state_q)
            IDLE: begin
                state_d = REQ;
                pc_d    = redirect_en ? redirect_pc : pc_q;
            end
            REQ: begin
                state_d = imem_ack ? WAIT : REQ;
                pc_d    = redirect_en ? redirect_pc : pc_q;
                drop_d  = redirect_en && imem_ack;
            end
            WAIT: begin
                // a redirect racing the response discards it; otherwise the pending response is dropped later
                if (imem_rvalid) begin
                    state_d = REQ;
                    drop_d  = 1'b0;
                    if (redirect_en) begin
                        pc_d = redirect_pc;
                    end else if (!drop_q) begin
                        ir_d     = imem_rdata;
                        pc_out_d = pc_q;
                        pc_d     = pc_q + ADDR_W'(PC_STEP);
                        valid_d  = 1'b1;
                        state_d  = HOLD;
                    end
                end else if (redirect_en) begin
                    pc_d   = redirect_pc;
                    drop_d = 1'b1;
                end
            end
            HOLD: begin
                if (redirect_en || dec_ready) begin
                    valid_d = 1'b0;
                    state_d = REQ;
                end
                pc_d = redirect_en ? redirect_pc : pc_q;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            pc_q     <= RESET_PC;
            ir_q     <= '0;
            pc_out_q <= '0;
            valid_q  <= 1'b0;
            drop_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            pc_out_q <= pc_out_d;
            valid_q  <= valid_d;
            drop_q   <= drop_d;
        end
    end

    assign imem_req    = state_q == REQ;
    assign imem_addr   = pc_q;
    assign instr_valid = valid_q;
    assign pc_out      = pc_out_q;
    assign opcode      = ir_q[31:26];
    assign rs          = ir_q[25:21];
    assign rt          = ir_q[20:16];
    assign rd          = ir_q[15:11];
    assign funct       = ir_q[3:0];
    assign imm16       = ir_q[15:0];

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_count_q, fetch_count_d, stall_count_q, stall_count_d;

    always_comb begin
        fetch_count_d = fetch_count_q + 32'(valid_q && dec_ready && !redirect_en);
        stall_count_d = stall_count_q + 32'(valid_q && !dec_ready);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_count_q <= '0;
            stall_count_q <= '0;
        end else begin
            fetch_count_q <= fetch_count_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign fetch_count = fetch_count_q;
    assign stall_count = stall_count_q;
`endif
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed + random fetch traffic; expected delivery stream kept in a queue, checked by a monitor.
module tb_instr_fetch_unit;
    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] imem_addr, imem_rdata, redirect_pc, pc_out;
    logic        imem_req, imem_ack, imem_rvalid, redirect_en, dec_ready, instr_valid;
    logic [5:0]  opcode;
    logic [4:0]  rs, rt, rd;
    logic [3:0]  funct;
    logic [15:0] imm16;
    logic [40:0] dut_fields;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_count, stall_count;
`endif

    instr_fetch_unit dut (
        .clk(clk), .reset(reset), .imem_addr(imem_addr), .imem_req(imem_req),
        .imem_ack(imem_ack), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .redirect_en(redirect_en), .redirect_pc(redirect_pc), .dec_ready(dec_ready),
        .instr_valid(instr_valid), .pc_out(pc_out), .opcode(opcode), .rs(rs), .rt(rt),
        .rd(rd), .funct(funct), .imm16(imm16)
`ifdef FETCH_PERF_CNT_EN
        , .fetch_count(fetch_count), .stall_count(stall_count)
`endif
    );

    always #5 clk = ~clk;
    assign dut_fields = {opcode, rs, rt, rd, funct, imm16};

    int          checks = 0, errors = 0, deliveries = 0;
    logic [31:0] exp_q[$];
    logic [31:0] mem[logic [31:0]];
    int          ack_pct, lat_lo, lat_hi, rdy_pct, redir_pct, spur_pct;
    bit          has_pend;
    logic [31:0] pend_addr;
    int          pend_dly;
    logic [31:0] m_fetch = 0, m_stall = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : ((a * 32'h9E3779B1) ^ 32'h3C5A96E1);
    endfunction

    function automatic logic [40:0] fields_of(input logic [31:0] w);
        return {w[31:26], w[25:21], w[20:16], w[15:11], w[3:0], w[15:0]};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h at %0t", name, act, exp, $time);
        end
    endtask

    // One cycle of memory responder + decode/redirect stimulus, driven just after the rising edge.
    task automatic step(input int rdy, input bit redir, input logic [31:0] tgt);
        logic [31:0] t;
        @(posedge clk);
        #2;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        imem_ack    = 1'b0;
        if (has_pend) begin
            if (pend_dly == 0) begin
                imem_rvalid = 1'b1;
                imem_rdata  = mem_word(pend_addr);
                has_pend    = 1'b0;
            end else pend_dly--;
        end else if ($urandom_range(99) < spur_pct) begin
            imem_rvalid = 1'b1;
            imem_rdata  = 32'hDEADBEEF;
        end
        if (imem_req && $urandom_range(99) < ack_pct) begin
            imem_ack  = 1'b1;
            has_pend  = 1'b1;
            pend_addr = imem_addr;
            pend_dly  = $urandom_range(lat_hi, lat_lo);
        end
        dec_ready = rdy < 0 ? ($urandom_range(99) < rdy_pct) : rdy[0];
        t = $urandom();
        t[1:0] = 2'b00;
        if ($urandom_range(7) == 0) t = 32'hFFFFFFFC;
        redirect_en = redir || ($urandom_range(99) < redir_pct);
        redirect_pc = redir ? tgt : t;
        if (redirect_en) begin
            exp_q.delete();
            exp_q.push_back(redirect_pc);
        end
    endtask

    task automatic wait_valid(input int rdy);
        int n = 0;
        do begin
            step(rdy, 1'b0, 32'h0);
            n++;
        end while (!instr_valid && n < 30);
        check("wait_valid", instr_valid, 1);
    endtask

    // Monitor: every delivered instruction must be the next one in program order from memory.
    initial begin
        bit          p_req = 0, p_ack = 0, p_redir = 0;
        logic [31:0] p_addr = 0, e;
        forever begin
            @(negedge clk);
            if (reset) begin
                p_req = 0;
                continue;
            end
            if (p_req && !p_ack && !p_redir) check("addr_stable", {imem_req, imem_addr}, {1'b1, p_addr});
            if (instr_valid) check("no_req_in_hold", imem_req, 0);
`ifdef FETCH_PERF_CNT_EN
            check("fetch_count", fetch_count, m_fetch);
            check("stall_count", stall_count, m_stall);
            if (instr_valid && !dec_ready) m_stall++;
`endif
            if (instr_valid && dec_ready && !redirect_en) begin
                m_fetch++;
                if (exp_q.size() == 0) check("exp_empty", 1, 0);
                else begin
                    e = exp_q.pop_front();
                    check("pc_out", pc_out, e);
                    check("fields", dut_fields, fields_of(mem_word(e)));
                    exp_q.push_back(e + 32'd4);
                    deliveries++;
                end
            end
            p_req = imem_req; p_ack = imem_ack; p_addr = imem_addr; p_redir = redirect_en;
        end
    end

    initial begin
        int d0;
        reset = 1'b1; imem_ack = 0; imem_rvalid = 0; imem_rdata = 0;
        redirect_en = 0; redirect_pc = 0; dec_ready = 0; has_pend = 0; pend_dly = 0; pend_addr = 0;
        ack_pct = 100; lat_lo = 0; lat_hi = 0; rdy_pct = 100; redir_pct = 0; spur_pct = 0;
        mem[32'h0] = 32'h00430820;
        mem[32'h4] = 32'h08000010;
        mem[32'h8] = 32'hFFFFFFFF;
        repeat (2) @(posedge clk);
        #2;
        check("rst_valid", instr_valid, 0);
        check("rst_req", imem_req, 0);
        check("rst_pc_out", pc_out, 0);
        check("rst_fields", dut_fields, 0);
        exp_q.push_back(32'h0);
        reset = 1'b0;
        // first fetch: request at cycle 1, valid at cycle 3
        step(1, 0, 0);
        check("t1_req_addr", {imem_req, imem_addr}, {1'b1, 32'h0});
        step(1, 0, 0);
        check("t1_wait_req", imem_req, 0);
        step(1, 0, 0);
        check("t1_valid", instr_valid, 1);
        check("t1_fields", dut_fields, {6'd0, 5'd2, 5'd3, 5'd1, 4'd0, 16'h0820});
        check("t1_pc_out", pc_out, 0);
        step(1, 0, 0);
        check("t1_next_addr", {imem_req, imem_addr}, {1'b1, 32'h4});
        // decode stall for 5 cycles, handshake on the 6th
        wait_valid(0);
        check("t2_opcode", opcode, 2);
        check("t2_req", imem_req, 0);
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 0);
            check("t2_hold_valid", instr_valid, 1);
            check("t2_hold_req", imem_req, 0);
        end
        step(1, 0, 0);
        check("t2_hs_valid", instr_valid, 1);
        lat_lo = 1; lat_hi = 1;
        step(-1, 0, 0);
        check("t2_next_addr", {imem_req, imem_addr}, {1'b1, 32'h8});
        // redirect while waiting; the old 0xFFFFFFFF response is dropped
        step(1, 1, 32'h100);
        check("t3_wait_req", imem_req, 0);
        step(1, 0, 0);
        check("t3_drop_valid", instr_valid, 0);
        lat_lo = 0; lat_hi = 0;
        step(1, 0, 0);
        check("t3_valid", instr_valid, 0);
        check("t3_addr", {imem_req, imem_addr}, {1'b1, 32'h100});
        // redirect in HOLD squashes despite dec_ready
        wait_valid(0);
        check("t4_pc_out", pc_out, 32'h100);
        check("t4_fields", dut_fields, fields_of(mem_word(32'h100)));
        step(1, 1, 32'h200);
        step(1, 0, 0);
        check("t4_squash_valid", instr_valid, 0);
        check("t4_addr", {imem_req, imem_addr}, {1'b1, 32'h200});
        // PC wrap at the top of the address space
        wait_valid(0);
        step(0, 1, 32'hFFFFFFFC);
        wait_valid(1);
        check("t5_pc_out", pc_out, 32'hFFFFFFFC);
        lat_lo = 1; lat_hi = 1;
        step(1, 0, 0);
        check("t5_wrap_addr", {imem_req, imem_addr}, {1'b1, 32'h0});
        // reset pulse in WAIT, stale response lands in IDLE
        step(1, 0, 0);
        check("t6_wait_req", imem_req, 0);
        #1;
        reset = 1'b1;
        m_fetch = 0; m_stall = 0;
        exp_q.delete();
        exp_q.push_back(32'h0);
        #1;
        check("t6_rst_valid", instr_valid, 0);
        check("t6_rst_fields", dut_fields, 0);
`ifdef FETCH_PERF_CNT_EN
        check("t6_rst_fetch_cnt", fetch_count, 0);
        check("t6_rst_stall_cnt", stall_count, 0);
`endif
        reset = 1'b0;
        has_pend = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata = 32'hFFFFFFFF;
        step(1, 0, 0);
        check("t6_restart_addr", {imem_req, imem_addr}, {1'b1, 32'h0});
        check("t6_valid", instr_valid, 0);
        check("t6_fields", dut_fields, 0);
        // random traffic
        ack_pct = 70; lat_lo = 0; lat_hi = 3; rdy_pct = 60; redir_pct = 6; spur_pct = 10;
        d0 = deliveries;
        repeat (4000) step(-1, 0, 0);
        check("progress", (deliveries - d0) > 100, 1);
        @(posedge clk);
        #2;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
